// File: rtl/mem_sweep_pkg.sv
// Shared definitions for the memory sweep controller: parameter defaults,
// FSM state encoding and the per-state output decode.
package mem_sweep_pkg;

   localparam int SIZE_DEFAULT    = 5;
   localparam int MEMSIZE_DEFAULT = 25;
   localparam int ROUNDS_DEFAULT  = 4;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOAD    = 3'd1,
      RD      = 3'd2,
      WAIT    = 3'd3,
      WR      = 3'd4,
      PUBLISH = 3'd5,
      DONE    = 3'd6
   } state_t;

   typedef struct packed {
      logic init;
      logic read;
      logic write;
      logic op_req;
      logic ok;
      logic done;
      logic busy;
   } ctrl_t;

   // Output pattern a state drives; the caller registers it alongside the state.
   function automatic ctrl_t decode_ctrl(input state_t s);
      ctrl_t c;
      c = '0;
      c.busy = (s != IDLE);
      case (s)
         LOAD:     c.init = 1'b1;
         RD, WAIT: begin
            c.read   = 1'b1;
            c.op_req = 1'b1;
         end
         WR: begin
            c.read  = 1'b1;
            c.write = 1'b1;
         end
         PUBLISH:  c.ok   = 1'b1;
         DONE:     c.done = 1'b1;
         default:  ;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/sweep_counter.sv
// Cell index counter (modulo MEMSIZE) and round counter for the sweep controller.
module sweep_counter
   import mem_sweep_pkg::*;
#(
   parameter int SIZE    = SIZE_DEFAULT,
   parameter int MEMSIZE = MEMSIZE_DEFAULT,
   parameter int ROUNDS  = ROUNDS_DEFAULT
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            clear,
   input  logic            step,
   output logic [SIZE-1:0] index,
   output logic [3:0]      round,
   output logic            last_cell,
   output logic            last_round
);

   assign last_cell  = (index == SIZE'(MEMSIZE - 1));
   assign last_round = (round == 4'(ROUNDS - 1));

   // On the final cell of the final round the round counter holds, so it never passes ROUNDS-1.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         index <= '0;
         round <= '0;
      end else if (clear) begin
         index <= '0;
         round <= '0;
      end else if (step) begin
         if (last_cell) begin
            index <= '0;
            if (!last_round)
               round <= round + 4'd1;
         end else begin
            index <= index + SIZE'(1);
         end
      end
   end

endmodule

// File: rtl/mem_sweep_ctrl.sv
// Sweeps a memory line cell by cell for ROUNDS rounds, handshaking each cell
// with an external bit operator, then publishes the result.
module mem_sweep_ctrl
   import mem_sweep_pkg::*;
#(
   parameter int SIZE    = SIZE_DEFAULT,
   parameter int MEMSIZE = MEMSIZE_DEFAULT,
   parameter int ROUNDS  = ROUNDS_DEFAULT
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            abort,
   input  logic            op_ack,
   output logic            init,
   output logic            firstread,
   output logic            read,
   output logic            write,
   output logic [SIZE-1:0] index,
   output logic            op_req,
   output logic            ok,
   output logic            busy,
   output logic            done,
   output logic [3:0]      round
);

   state_t state;
   state_t state_next;
   ctrl_t  ctrl;
   logic   abort_hit;
   logic   fr_next;
   logic   cnt_clear;
   logic   cnt_step;
   logic   last_cell;
   logic   last_round;

   always_comb begin
      state_next = state;
      abort_hit  = abort && (state != IDLE) && (state != DONE);
      case (state)
         IDLE:    if (start) state_next = LOAD;
         LOAD:    state_next = RD;
         RD:      state_next = WAIT;
         WAIT:    if (op_ack) state_next = WR;
         WR:      state_next = (last_cell && last_round) ? PUBLISH : RD;
         PUBLISH: state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
      if (abort_hit)
         state_next = IDLE;
   end

   assign cnt_clear = abort_hit || (state == IDLE) || (state == LOAD);
   assign cnt_step  = (state == WR) && !abort_hit;

   // firstread must track the round value that will be current next cycle,
   // which differs from the present one only when WR wraps the last cell.
   assign fr_next = ((state_next == RD) || (state_next == WAIT)) &&
                    ((state == LOAD) || ((round == 4'd0) && !((state == WR) && last_cell)));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         ctrl      <= '0;
         firstread <= 1'b0;
      end else begin
         state     <= state_next;
         ctrl      <= decode_ctrl(state_next);
         firstread <= fr_next;
      end
   end

   assign init   = ctrl.init;
   assign read   = ctrl.read;
   assign write  = ctrl.write;
   assign op_req = ctrl.op_req;
   assign ok     = ctrl.ok;
   assign done   = ctrl.done;
   assign busy   = ctrl.busy;

   sweep_counter #(
      .SIZE    (SIZE),
      .MEMSIZE (MEMSIZE),
      .ROUNDS  (ROUNDS)
   ) u_counter (
      .clk        (clk),
      .rst        (rst),
      .clear      (cnt_clear),
      .step       (cnt_step),
      .index      (index),
      .round      (round),
      .last_cell  (last_cell),
      .last_round (last_round)
   );

endmodule

// File: tb/tb_mem_sweep_ctrl.sv
// Scoreboard bench for mem_sweep_ctrl: one ROUNDS=1 and one ROUNDS=2 instance.
module tb_mem_sweep_ctrl;

   localparam logic [1:0] K_INIT = 2'd0;
   localparam logic [1:0] K_WR   = 2'd1;
   localparam logic [1:0] K_OK   = 2'd2;
   localparam logic [1:0] K_DONE = 2'd3;

   typedef struct packed {
      logic [1:0]  kind;
      logic [3:0]  rnd;
      logic [4:0]  idx;
      logic [15:0] cycles;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;

   logic start1 = 1'b0, abort1 = 1'b0, op_ack1 = 1'b1;
   logic init1, firstread1, read1, write1, op_req1, ok1, busy1, done1;
   logic [4:0] index1;
   logic [3:0] round1;

   logic start2 = 1'b0, abort2 = 1'b0, op_ack2 = 1'b1;
   logic init2, firstread2, read2, write2, op_req2, ok2, busy2, done2;
   logic [4:0] index2;
   logic [3:0] round2;

   exp_t q1[$];
   exp_t q2[$];
   int checks = 0;
   int fails  = 0;
   int cyc    = 0;
   int init_cyc[2];
   int wr_cnt[2];

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   mem_sweep_ctrl #(.SIZE(5), .MEMSIZE(25), .ROUNDS(1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .abort(abort1), .op_ack(op_ack1),
      .init(init1), .firstread(firstread1), .read(read1), .write(write1),
      .index(index1), .op_req(op_req1), .ok(ok1), .busy(busy1), .done(done1),
      .round(round1)
   );

   mem_sweep_ctrl #(.SIZE(5), .MEMSIZE(25), .ROUNDS(2)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .abort(abort2), .op_ack(op_ack2),
      .init(init2), .firstread(firstread2), .read(read2), .write(write2),
      .index(index2), .op_req(op_req2), .ok(ok2), .busy(busy2), .done(done2),
      .round(round2)
   );

   task automatic check_output(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         fails++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   function automatic exp_t mk(input logic [1:0] k, input int r, input int i, input int c);
      exp_t e;
      e.kind   = k;
      e.rnd    = 4'(r);
      e.idx    = 5'(i);
      e.cycles = 16'(c);
      return e;
   endfunction

   task automatic push_exp(input int id, input exp_t e);
      if (id == 1) q1.push_back(e);
      else         q2.push_back(e);
   endtask

   // Full job: LOAD + 3 cycles per cell + PUBLISH + DONE, plus any ack stall.
   task automatic push_job(input int id, input int rounds, input int stall);
      push_exp(id, mk(K_INIT, 0, 0, 0));
      for (int r = 0; r < rounds; r++)
         for (int i = 0; i < 25; i++)
            push_exp(id, mk(K_WR, r, i, 0));
      push_exp(id, mk(K_OK, 0, 0, 0));
      push_exp(id, mk(K_DONE, 0, 0, 3 + 75 * rounds + stall));
   endtask

   task automatic push_partial(input int id, input int nwrites);
      push_exp(id, mk(K_INIT, 0, 0, 0));
      for (int i = 0; i < nwrites; i++)
         push_exp(id, mk(K_WR, 0, i, 0));
   endtask

   task automatic monitor(input int id, input logic init_o, input logic write_o,
                          input logic ok_o, input logic done_o, input logic op_req_o,
                          input logic fr_o, input logic [4:0] idx_o, input logic [3:0] rnd_o);
      exp_t e;
      logic [1:0] k;
      bit have;
      if (op_req_o)
         check_output($sformatf("firstread_dut%0d", id), int'(fr_o), int'(rnd_o == 4'd0));
      if (init_o || write_o || ok_o || done_o) begin
         k = init_o ? K_INIT : write_o ? K_WR : ok_o ? K_OK : K_DONE;
         if (write_o) wr_cnt[id-1]++;
         have = (id == 1) ? (q1.size() > 0) : (q2.size() > 0);
         if (!have) begin
            checks++;
            fails++;
            $display("[TB] FAIL unexpected_event_dut%0d: got kind %0d idx %0d rnd %0d, expected none",
                     id, k, idx_o, rnd_o);
         end else begin
            e = (id == 1) ? q1.pop_front() : q2.pop_front();
            check_output($sformatf("event_kind_dut%0d", id), int'(k), int'(e.kind));
            if (k == K_INIT)
               init_cyc[id-1] = cyc;
            if (k == K_WR) begin
               check_output($sformatf("wr_index_dut%0d", id), int'(idx_o), int'(e.idx));
               check_output($sformatf("wr_round_dut%0d", id), int'(rnd_o), int'(e.rnd));
            end
            if (k == K_DONE)
               check_output($sformatf("job_cycles_dut%0d", id), cyc - init_cyc[id-1] + 1, int'(e.cycles));
         end
      end
   endtask

   // Scoreboard side: pops expectations whenever either DUT shows an event.
   always @(negedge clk) begin
      if (rst) begin
         monitor(1, init1, write1, ok1, done1, op_req1, firstread1, index1, round1);
         monitor(2, init2, write2, ok2, done2, op_req2, firstread2, index2, round2);
      end
   end

   // what: 0 = op_req at idx/rnd, 1 = write at idx/rnd, 2 = done
   task automatic wait_for(input int id, input int what, input int idx, input int rnd, input string name);
      bit hit;
      logic rq, wr, dn;
      logic [4:0] ix;
      logic [3:0] rd;
      hit = 1'b0;
      for (int n = 0; n < 3000 && !hit; n++) begin
         @(negedge clk);
         rq = (id == 1) ? op_req1 : op_req2;
         wr = (id == 1) ? write1  : write2;
         dn = (id == 1) ? done1   : done2;
         ix = (id == 1) ? index1  : index2;
         rd = (id == 1) ? round1  : round2;
         case (what)
            0:       hit = rq && (ix == 5'(idx)) && (rd == 4'(rnd));
            1:       hit = wr && (ix == 5'(idx)) && (rd == 4'(rnd));
            default: hit = dn;
         endcase
      end
      check_output({"reached_", name}, int'(hit), 1);
   endtask

   task automatic pulse_start(input int id);
      @(negedge clk);
      if (id == 1) start1 = 1'b1; else start2 = 1'b1;
      @(negedge clk);
      if (id == 1) start1 = 1'b0; else start2 = 1'b0;
   endtask

   task automatic apply_stimulus();
      // Reset state while rst is held low
      #23;
      check_output("rst_busy1", int'(busy1), 0);
      check_output("rst_init1", int'(init1), 0);
      check_output("rst_busy2", int'(busy2), 0);
      check_output("rst_index2", int'(index2), 0);
      check_output("rst_round2", int'(round2), 0);
      @(negedge clk);
      rst = 1'b1;

      // ROUNDS=1, ack tied high
      push_job(1, 1, 0);
      pulse_start(1);
      wait_for(1, 2, 0, 0, "done_job1");
      check_output("writes_job1", wr_cnt[0], 25);

      // ROUNDS=2, ack held off for the first 3 WAIT cycles of cell 7
      push_job(2, 2, 2);
      pulse_start(2);
      wait_for(2, 0, 7, 0, "rd_idx7");
      op_ack2 = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check_output($sformatf("wait_index_%0d", k), int'(index2), 7);
         check_output($sformatf("wait_op_req_%0d", k), int'(op_req2), 1);
         check_output($sformatf("wait_nowrite_%0d", k), int'(write2), 0);
      end
      op_ack2 = 1'b1;
      wait_for(2, 2, 0, 0, "done_job2");
      check_output("writes_job2", wr_cnt[1], 50);

      // Abort in WAIT at cell 12 with op_ack also high
      push_partial(2, 12);
      pulse_start(2);
      wait_for(2, 0, 12, 0, "rd_idx12");
      @(negedge clk);
      check_output("abort_in_wait", int'(op_req2 && !write2), 1);
      abort2 = 1'b1;
      @(negedge clk);
      abort2 = 1'b0;
      check_output("abort_busy", int'(busy2), 0);
      check_output("abort_write", int'(write2), 0);
      check_output("abort_index", int'(index2), 0);
      check_output("abort_round", int'(round2), 0);
      repeat (5) @(negedge clk);
      check_output("abort_queue_left", q2.size(), 0);
      check_output("abort_writes", wr_cnt[1], 62);

      // Asynchronous reset in the middle of WR
      push_partial(2, 4);
      pulse_start(2);
      wait_for(2, 1, 3, 0, "wr_idx3");
      #2 rst = 1'b0;
      #1;
      check_output("arst_write", int'(write2), 0);
      check_output("arst_read", int'(read2), 0);
      check_output("arst_busy", int'(busy2), 0);
      check_output("arst_index", int'(index2), 0);
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check_output("arst_stays_idle", int'(busy2), 0);
      push_job(2, 2, 0);
      pulse_start(2);
      wait_for(2, 2, 0, 0, "done_job_after_rst");
      check_output("writes_after_rst", wr_cnt[1], 116);

      // start held high: one job, then IDLE, then a fresh LOAD
      push_job(1, 1, 0);
      @(negedge clk);
      start1 = 1'b1;
      wait_for(1, 2, 0, 0, "done_held1");
      push_job(1, 1, 0);
      @(negedge clk);
      check_output("held_idle_after_done", int'(busy1), 0);
      @(negedge clk);
      check_output("held_load_after_idle", int'(init1), 1);
      start1 = 1'b0;
      wait_for(1, 2, 0, 0, "done_held2");
      check_output("writes_held", wr_cnt[0], 75);
      repeat (3) @(negedge clk);
      check_output("q1_drained", q1.size(), 0);
      check_output("q2_drained", q2.size(), 0);
   endtask

   initial begin
      wr_cnt[0] = 0;
      wr_cnt[1] = 0;
      init_cyc[0] = 0;
      init_cyc[1] = 0;
      apply_stimulus();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
